// File: rtl/pa_ide.sv
// pa_ide: shared IDE register map, command codes and controller state types.
package pa_ide;
  localparam logic [2:0] DATA     = 3'd0;
  localparam logic [2:0] LBA0     = 3'd3;
  localparam logic [2:0] LBA1     = 3'd4;
  localparam logic [2:0] LBA2     = 3'd5;
  localparam logic [2:0] CMD_STAT = 3'd7;
  localparam logic [7:0] CMD_READ  = 8'h20;
  localparam logic [7:0] CMD_WRITE = 8'h30;
  localparam int STAT_BUSY_BIT = 3;
  typedef enum logic [2:0] {
    S_IDLE, S_LBA, S_CMD, S_WAIT_BSY, S_XFER, S_WAIT_RDY, S_DONE, S_ERR
  } t_ideCtrlState;
  typedef enum logic [2:0] {B_IDLE, B_SETUP, B_STROBE, B_HOLD, B_GAP} t_ideBusState;
endpackage

// File: rtl/ide_bus_cycle.sv
// ide_bus_cycle: one IDE register access (SETUP, STROBE x N, HOLD, GAP); owns all strobe timing.
module ide_bus_cycle
  import pa_ide::*;
#(
  parameter int STROBE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       req,
  input  logic       rw,
  input  logic [2:0] addr,
  input  logic [7:0] wdata,
  output logic       idle,
  output logic       ack,
  output logic [7:0] rdata,
  output logic       ide_ce_n,
  output logic       ide_oe_n,
  output logic       ide_we_n,
  output logic [2:0] ide_addr,
  output logic [7:0] ide_wdata,
  input  logic [7:0] ide_rdata
);
  t_ideBusState state_q, state_d;
  logic [3:0] scnt_q, scnt_d;
  logic rw_q;
  logic strobe_last;
  assign strobe_last = scnt_q == 4'(STROBE_CYCLES - 1);
  assign idle = state_q == B_IDLE;
  assign ack  = state_q == B_GAP;
  assign ide_ce_n = !(state_q inside {B_SETUP, B_STROBE, B_HOLD});
  assign ide_oe_n = !(state_q == B_STROBE && !rw_q);
  assign ide_we_n = !(state_q == B_STROBE && rw_q);
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q   <= B_IDLE;
      scnt_q    <= '0;
      rw_q      <= 1'b0;
      ide_addr  <= '0;
      ide_wdata <= '0;
      rdata     <= '0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      if (idle && req) begin
        rw_q      <= rw;
        ide_addr  <= addr;
        ide_wdata <= wdata;
      end
      if (state_q == B_STROBE && strobe_last && !rw_q) rdata <= ide_rdata;
    end
  end
  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    case (state_q)
      B_IDLE:   state_d = req ? B_SETUP : B_IDLE;
      B_SETUP: begin
        state_d = B_STROBE;
        scnt_d  = '0;
      end
      B_STROBE: begin
        scnt_d  = scnt_q + 4'd1;
        state_d = strobe_last ? B_HOLD : B_STROBE;
      end
      B_HOLD:   state_d = B_GAP;
      default:  state_d = B_IDLE;
    endcase
  end
endmodule

// File: rtl/ide_sector_ctrl.sv
// ide_sector_ctrl: moves one sector between buffer RAM and the IDE data register,
// programming LBA, issuing the command and polling status around the data phase.
module ide_sector_ctrl
  import pa_ide::*;
#(
  parameter int STROBE_CYCLES = 2,
  parameter int TIMEOUT       = 1024,
  parameter int MEM_AW        = 16,
  parameter int SECTOR_BYTES  = 512
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              start,
  input  logic              dir,
  input  logic [23:0]       lba,
  input  logic [MEM_AW-1:0] mem_base,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              ide_ce_n,
  output logic              ide_oe_n,
  output logic              ide_we_n,
  output logic [2:0]        ide_addr,
  output logic [7:0]        ide_wdata,
  input  logic [7:0]        ide_rdata
);
  localparam int PW = $clog2(TIMEOUT + 1);
  t_ideCtrlState state_q, state_d;
  logic dir_q;
  logic [23:0] lba_q;
  logic [9:0] cnt_q, cnt_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic req, rw, ack, bus_idle, stat_bsy, poll_last;
  logic [2:0] req_addr;
  logic [7:0] req_wdata, rdata;
  assign stat_bsy  = rdata[STAT_BUSY_BIT];
  assign poll_last = poll_q == PW'(TIMEOUT - 1);
  assign busy      = state_q inside {S_LBA, S_CMD, S_WAIT_BSY, S_XFER, S_WAIT_RDY};
  assign done      = state_q == S_DONE;
  assign error     = state_q == S_ERR;
  assign mem_we    = state_q == S_XFER && !dir_q && ack;
  assign mem_addr  = addr_q;
  assign mem_wdata = rdata;
  ide_bus_cycle #(.STROBE_CYCLES(STROBE_CYCLES)) u_bus (
    .clk       (clk),
    .arst      (arst),
    .req       (req),
    .rw        (rw),
    .addr      (req_addr),
    .wdata     (req_wdata),
    .idle      (bus_idle),
    .ack       (ack),
    .rdata     (rdata),
    .ide_ce_n  (ide_ce_n),
    .ide_oe_n  (ide_oe_n),
    .ide_we_n  (ide_we_n),
    .ide_addr  (ide_addr),
    .ide_wdata (ide_wdata),
    .ide_rdata (ide_rdata)
  );
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      lba_q   <= '0;
      cnt_q   <= '0;
      poll_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      poll_q  <= poll_d;
      addr_q  <= addr_d;
      if (state_q == S_IDLE && start) begin
        dir_q <= dir;
        lba_q <= lba;
      end
    end
  end
  // Requests go out only while the bus engine is idle; the RAM address for a
  // disk write is advanced when its byte is accepted, so the next byte is
  // already on mem_rdata by the following request.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    poll_d    = poll_q;
    addr_d    = addr_q;
    req       = 1'b0;
    rw        = 1'b0;
    req_addr  = CMD_STAT;
    req_wdata = '0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_LBA;
        cnt_d   = '0;
        addr_d  = mem_base;
      end
      S_LBA: begin
        req       = bus_idle;
        rw        = 1'b1;
        req_addr  = cnt_q[1] ? LBA2 : cnt_q[0] ? LBA1 : LBA0;
        req_wdata = cnt_q[1] ? lba_q[23:16] : cnt_q[0] ? lba_q[15:8] : lba_q[7:0];
        if (ack) begin
          cnt_d   = cnt_q == 10'd2 ? '0 : cnt_q + 10'd1;
          state_d = cnt_q == 10'd2 ? S_CMD : S_LBA;
        end
      end
      S_CMD: begin
        req       = bus_idle;
        rw        = 1'b1;
        req_wdata = dir_q ? CMD_WRITE : CMD_READ;
        if (ack) begin
          state_d = S_WAIT_BSY;
          poll_d  = '0;
        end
      end
      S_WAIT_BSY: begin
        req = bus_idle;
        if (ack) begin
          poll_d  = poll_last ? poll_q : poll_q + 1'b1;
          state_d = stat_bsy ? S_XFER : poll_last ? S_ERR : S_WAIT_BSY;
        end
      end
      S_XFER: begin
        req       = bus_idle;
        rw        = dir_q;
        req_addr  = DATA;
        req_wdata = mem_rdata;
        if (dir_q ? req : ack) addr_d = addr_q + 1'b1;
        if (ack) begin
          cnt_d = cnt_q == 10'(SECTOR_BYTES - 1) ? '0 : cnt_q + 10'd1;
          if (cnt_q == 10'(SECTOR_BYTES - 1)) begin
            state_d = S_WAIT_RDY;
            poll_d  = '0;
          end
        end
      end
      S_WAIT_RDY: begin
        req = bus_idle;
        if (ack) begin
          poll_d  = poll_last ? poll_q : poll_q + 1'b1;
          state_d = !stat_bsy ? S_DONE : poll_last ? S_ERR : S_WAIT_RDY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_ide_sector_ctrl.sv
// tb_ide_sector_ctrl: random sector transfers against a behavioural IDE disk,
// a synchronous RAM and a bus-protocol monitor.
module tb_ide_sector_ctrl;
  localparam int SC = 3;
  localparam int TO = 16;
  logic clk = 0, arst = 0, start = 0, dir = 0;
  logic [23:0] lba = '0;
  logic [15:0] mem_base = '0, mem_addr;
  logic busy, done, error, mem_we, ide_ce_n, ide_oe_n, ide_we_n;
  logic [7:0] mem_wdata, mem_rdata = '0, ide_wdata, ide_rdata = '0;
  logic [2:0] ide_addr;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  ide_sector_ctrl #(.STROBE_CYCLES(SC), .TIMEOUT(TO), .MEM_AW(16), .SECTOR_BYTES(512)) dut (
    .clk(clk), .arst(arst), .start(start), .dir(dir), .lba(lba), .mem_base(mem_base),
    .busy(busy), .done(done), .error(error), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .ide_ce_n(ide_ce_n), .ide_oe_n(ide_oe_n),
    .ide_we_n(ide_we_n), .ide_addr(ide_addr), .ide_wdata(ide_wdata), .ide_rdata(ide_rdata)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  logic [7:0] ram [65536];
  logic [7:0] image [65536];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end
  // Disk model: status bit3 rises a few polls after a command, stays up for the
  // 512 data transfers, then drops a few polls later; image offset = lba + byte.
  logic [23:0] m_lba = '0;
  logic [7:0] m_cmd = '0;
  logic m_bit3 = 0;
  bit stuck = 0;
  int m_phase = 0, m_delay = 0, m_ptr = 0, m_cmds = 0, m_stat_reads = 0, m_data_acc = 0;
  logic [2:0] wr_log [$];
  always @(negedge ide_oe_n) if (!arst) begin
    if (ide_addr == 3'd7) begin
      m_stat_reads++;
      if (stuck) m_bit3 = 0;
      else if (m_phase == 1) begin
        m_bit3 = m_delay == 0;
        if (m_delay == 0) m_phase = 2; else m_delay--;
      end else if (m_phase == 3) begin
        m_bit3 = m_delay != 0;
        if (m_delay != 0) m_delay--;
      end else m_bit3 = m_phase == 2;
      ide_rdata = {4'h0, m_bit3, 3'h0};
    end else if (ide_addr == 3'd0) begin
      m_data_acc++;
      ide_rdata = image[m_lba[15:0] + 16'(m_ptr)];
      m_ptr++;
      if (m_ptr == 512) begin m_phase = 3; m_delay = $urandom_range(0, 4); end
    end else ide_rdata = 8'($urandom);
  end
  always @(posedge ide_we_n) if (!arst) begin
    if (ide_addr != 3'd0) wr_log.push_back(ide_addr);
    case (ide_addr)
      3'd3: m_lba[7:0] = ide_wdata;
      3'd4: m_lba[15:8] = ide_wdata;
      3'd5: m_lba[23:16] = ide_wdata;
      3'd7: begin
        m_cmd = ide_wdata; m_phase = 1; m_delay = $urandom_range(0, 4); m_ptr = 0; m_cmds++;
      end
      3'd0: begin
        m_data_acc++;
        image[m_lba[15:0] + 16'(m_ptr)] = ide_wdata;
        m_ptr++;
        if (m_ptr == 512) begin m_phase = 3; m_delay = $urandom_range(0, 4); end
      end
      default: ;
    endcase
  end
  int both_low = 0, unstable = 0, bad_len = 0, bad_strb = 0, n_acc = 0, run = 0, srun = 0;
  int n_both = 0;
  logic ps = 0;
  logic [10:0] pv = '0;
  always @(negedge clk) if (arst) begin
    run = 0; srun = 0; ps = 0;
  end else begin
    if (!ide_oe_n && !ide_we_n) both_low++;
    if (done && error) n_both++;
    if (!ide_oe_n || !ide_we_n) begin
      if (ps && {ide_addr, ide_wdata} != pv) unstable++;
      srun++;
    end else begin
      if (srun != 0 && srun != SC) bad_strb++;
      srun = 0;
    end
    ps = !ide_oe_n || !ide_we_n;
    pv = {ide_addr, ide_wdata};
    if (!ide_ce_n) run++;
    else begin
      if (run != 0) begin n_acc++; if (run != SC + 2) bad_len++; end
      run = 0;
    end
  end
  bit got_done, got_err;
  task automatic start_op(input logic d, input logic [23:0] l, input logic [15:0] b);
    @(negedge clk);
    dir = d; lba = l; mem_base = b; start = 1;
    @(negedge clk);
    start = 0;
    chk("busy_after_start", busy, 1);
  endtask
  task automatic wait_end(input string tag);
    int low = 0;
    got_done = 0; got_err = 0;
    for (int i = 0; i < 20000; i++) begin
      if (done || error) begin got_done = done; got_err = error; break; end
      if (!busy) low++;
      @(negedge clk);
    end
    chk({tag, "_ended"}, got_done | got_err, 1);
    chk({tag, "_busy_held"}, low, 0);
    @(negedge clk);
    chk({tag, "_single_pulse"}, {done, error, busy}, 0);
  endtask
  task automatic check_read(input string tag, input logic [23:0] l, input logic [15:0] b);
    int bad = 0;
    for (int i = 0; i < 512; i++) if (ram[b + 16'(i)] !== image[l[15:0] + 16'(i)]) bad++;
    chk({tag, "_ram_bytes_bad"}, bad, 0);
  endtask
  task automatic check_write(input string tag, input logic [23:0] l, input logic [15:0] b);
    int bad = 0;
    for (int i = 0; i < 512; i++) if (image[l[15:0] + 16'(i)] !== ram[b + 16'(i)]) bad++;
    chk({tag, "_disk_bytes_bad"}, bad, 0);
  endtask
  task automatic do_op(input string tag, input logic d, input logic [23:0] l, input logic [15:0] b);
    logic [11:0] ord;
    wr_log.delete();
    start_op(d, l, b);
    wait_end(tag);
    chk({tag, "_done_not_error"}, {got_done, got_err}, 2'b10);
    ord = wr_log.size() == 4 ? {wr_log[0], wr_log[1], wr_log[2], wr_log[3]} : 12'hfff;
    chk({tag, "_reg_order"}, ord, {3'd3, 3'd4, 3'd5, 3'd7});
    chk({tag, "_lba"}, m_lba, l);
    chk({tag, "_cmd"}, m_cmd, d ? 8'h30 : 8'h20);
    if (d) check_write(tag, l, b); else check_read(tag, l, b);
  endtask
  localparam logic [56:0] RST_VAL = {3'b111, 3'd0, 8'd0, 16'd0, 1'b0, 8'd0, 3'b000, 15'd0};
  function automatic logic [56:0] outs();
    return {ide_ce_n, ide_oe_n, ide_we_n, ide_addr, ide_wdata, mem_addr, mem_we, mem_wdata,
            busy, done, error, 15'd0};
  endfunction
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [23:0] l;
    logic [15:0] b;
    logic [7:0] lo, hi;
    int c0, s0, d0;
    bit found;
    for (int i = 0; i < 65536; i++) begin ram[i] = 8'($urandom); image[i] = 8'($urandom); end
    #1 arst = 1;
    #2 chk("reset_outputs", outs(), RST_VAL);
    @(negedge clk); @(negedge clk); arst = 0;
    // disk read into 0x1000
    lo = ram[16'h0FFF]; hi = ram[16'h1200];
    do_op("read", 0, 24'h000200, 16'h1000);
    chk("read_below_untouched", ram[16'h0FFF], lo);
    chk("read_above_untouched", ram[16'h1200], hi);
    // disk write of an incrementing pattern
    for (int i = 0; i < 512; i++) ram[16'h2000 + 16'(i)] = 8'(i);
    do_op("write", 1, 24'h000400, 16'h2000);
    chk("write_pattern_ff", image[16'h04FF], 8'hFF);
    chk("write_pattern_wrap", image[16'h0500], 8'h00);
    chk("write_status_bit3", m_bit3, 0);
    // random transfers
    for (int k = 0; k < 3; k++) begin
      l = 24'($urandom); b = 16'($urandom);
      do_op($sformatf("rand%0d", k), k[0], l, b);
    end
    // timeout: disk never raises bit3
    stuck = 1; s0 = m_stat_reads; d0 = m_data_acc;
    start_op(0, 24'h000010, 16'h4000);
    wait_end("timeout");
    chk("timeout_flags", {got_done, got_err}, 2'b01);
    chk("timeout_status_reads", m_stat_reads - s0, TO);
    chk("timeout_no_data", m_data_acc - d0, 0);
    stuck = 0;
    // reset while reading byte 100
    start_op(0, 24'h001234, 16'h3000);
    found = 0;
    for (int i = 0; i < 5000 && !found; i++) begin
      @(negedge clk);
      found = m_ptr == 101 && !ide_oe_n;
    end
    chk("reset_reached_byte100", found, 1);
    #2 arst = 1;
    #1 chk("reset_mid_outputs", outs(), RST_VAL);
    @(negedge clk); @(negedge clk); arst = 0;
    do_op("after_reset", 0, 24'($urandom), 16'($urandom));
    // address wrap with an ignored second start
    l = 24'($urandom); c0 = m_cmds;
    start_op(0, l, 16'hFF00);
    found = 0;
    for (int i = 0; i < 5000 && !found; i++) begin
      @(negedge clk);
      found = m_ptr == 11;
    end
    chk("wrap_reached_byte10", found, 1);
    dir = 1; lba = 24'h000777; mem_base = 16'h5555; start = 1;
    @(negedge clk);
    start = 0;
    wait_end("wrap");
    chk("wrap_done", {got_done, got_err}, 2'b10);
    chk("wrap_single_command", m_cmds - c0, 1);
    chk("wrap_byte256_at_0", ram[16'h0000], image[l[15:0] + 16'd256]);
    check_read("wrap", l, 16'hFF00);
    // bus protocol summary
    chk("strobes_both_low", both_low, 0);
    chk("addr_wdata_unstable", unstable, 0);
    chk("access_length", bad_len, 0);
    chk("strobe_length", bad_strb, 0);
    chk("accesses_seen", n_acc > 3000, 1);
    chk("done_error_overlap", n_both, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
